// File: rtl/alu_share_arbiter_pkg.sv
// Shared state encoding, flag positions and helpers for the two-requester ALU arbiter.
package alu_share_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int FLAGW      = 4;
    localparam int FLAG_CARRY = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_NEG   = 0;

    // The WAIT counter starts at latency-1 so that it spends exactly ALU_LAT cycles in WAIT.
    function automatic logic [3:0] lat_load(input int lat);
        return 4'(lat - 1);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, ALU-side and response signals for alu_share_arbiter.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CMDW  = 3
);
    import alu_share_arbiter_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [CMDW-1:0]  req0_cmd;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [CMDW-1:0]  req1_cmd;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [CMDW-1:0]  alu_cmd;
    logic             alu_start;
    logic [WIDTH-1:0] alu_result;
    logic [FLAGW-1:0] alu_flags;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic [FLAGW-1:0] resp_flags;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cmd,
        input  req1_valid, req1_a, req1_b, req1_cmd,
        input  alu_result, alu_flags, resp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_cmd, alu_start,
        output resp_valid, resp_id, resp_result, resp_flags
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cmd,
        output req1_valid, req1_a, req1_b, req1_cmd,
        output alu_result, alu_flags, resp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_cmd, alu_start,
        input  resp_valid, resp_id, resp_result, resp_flags
    );

endinterface

// File: rtl/mux2by1.sv
// One-bit 2:1 multiplexer; ctl=1 selects in1.
module mux2by1 (
    input  logic in0,
    input  logic in1,
    input  logic ctl,
    output logic out
);
    assign out = ctl ? in1 : in0;
endmodule

// File: rtl/mux32layers2by1.sv
// 32-bit 2:1 multiplexer built as a layer of one-bit mux2by1 cells; ctl=1 selects in1.
module mux32layers2by1 (
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic        ctl,
    output logic [31:0] out
);
    for (genvar i = 0; i < 32; i++) begin : g_bit
        mux2by1 u_bit (.in0(in0[i]), .in1(in1[i]), .ctl(ctl), .out(out[i]));
    end
endmodule

// File: rtl/rr_pick2.sv
// Two-request round-robin pick: a lone requester wins, a tie goes to prio.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic gnt,
    output logic any
);
    assign any = req0 | req1;
    assign gnt = (req0 & ~req1) ? 1'b0 :
                 (~req0 & req1) ? 1'b1 : prio;
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one fixed-latency ALU between two requesters,
// with a single outstanding operation and a valid/ready response.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 2,
    parameter int CMDW    = 3
) (
    input  logic                clk,
    input  logic                reset,
    alu_share_arbiter_if.slave  bus
);

    arb_state_e       state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [CMDW-1:0]  alu_cmd_q, alu_cmd_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic [FLAGW-1:0] resp_flags_q, resp_flags_d;

    logic             gnt;
    logic             any_valid;
    logic             accept;
    logic [WIDTH-1:0] mux_a;
    logic [WIDTH-1:0] mux_b;
    logic [CMDW-1:0]  mux_cmd;

    rr_pick2 u_pick (
        .req0 (bus.req0_valid),
        .req1 (bus.req1_valid),
        .prio (prio_q),
        .gnt  (gnt),
        .any  (any_valid)
    );

    mux32layers2by1 u_mux_a (.in0(bus.req0_a), .in1(bus.req1_a), .ctl(gnt), .out(mux_a));
    mux32layers2by1 u_mux_b (.in0(bus.req0_b), .in1(bus.req1_b), .ctl(gnt), .out(mux_b));

    for (genvar i = 0; i < CMDW; i++) begin : g_cmd
        mux2by1 u_cmd (.in0(bus.req0_cmd[i]), .in1(bus.req1_cmd[i]), .ctl(gnt), .out(mux_cmd[i]));
    end

    // Ready is held low while reset is asserted so nothing looks accepted during reset.
    assign accept         = (state_q == IDLE) & any_valid & ~reset;
    assign bus.req0_ready = accept & ~gnt;
    assign bus.req1_ready = accept & gnt;
    assign bus.alu_start  = (state_q == ISSUE);
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_cmd    = alu_cmd_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_flags = resp_flags_q;

    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_cmd_d     = alu_cmd_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_flags_d  = resp_flags_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_a_d   = mux_a;
                    alu_b_d   = mux_b;
                    alu_cmd_d = mux_cmd;
                    owner_d   = gnt;
                    prio_d    = ~gnt;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = lat_load(ALU_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    resp_result_d = bus.alu_result;
                    resp_flags_d  = bus.alu_flags;
                    resp_id_d     = owner_q;
                    resp_valid_d  = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            prio_q        <= 1'b0;
            owner_q       <= 1'b0;
            cnt_q         <= 4'd0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_cmd_q     <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_cmd_q     <= alu_cmd_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_flags_q  <= resp_flags_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (ALU_LAT=2 main build, plus 1 and 15).
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    logic [3:0] flags_drv;
    logic [3:0] flags_lat;

    alu_share_arbiter_if #(.WIDTH(32), .CMDW(3)) bus ();
    alu_share_arbiter_if #(.WIDTH(32), .CMDW(3)) bus1 ();
    alu_share_arbiter_if #(.WIDTH(32), .CMDW(3)) bus15 ();

    alu_share_arbiter #(.WIDTH(32), .ALU_LAT(2), .CMDW(3)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    alu_share_arbiter #(.WIDTH(32), .ALU_LAT(1), .CMDW(3)) dut_lat1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    alu_share_arbiter #(.WIDTH(32), .ALU_LAT(15), .CMDW(3)) dut_lat15 (
        .clk(clk), .reset(reset), .bus(bus15)
    );

    // Simple ALU model: 0 add, 1 subtract, anything else xor.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] cmd);
        if (cmd == 3'd0) return a + b;
        if (cmd == 3'd1) return a - b;
        return a ^ b;
    endfunction

    assign bus.alu_result   = alu_model(bus.alu_a, bus.alu_b, bus.alu_cmd);
    assign bus.alu_flags    = flags_drv;
    assign bus1.alu_result  = alu_model(bus1.alu_a, bus1.alu_b, bus1.alu_cmd);
    assign bus1.alu_flags   = flags_lat;
    assign bus15.alu_result = alu_model(bus15.alu_a, bus15.alu_b, bus15.alu_cmd);
    assign bus15.alu_flags  = flags_lat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [107:0] outs;
        step();
        bus.req0_valid = 1'b1;
        #1;
        outs = {bus.alu_a, bus.alu_b, bus.alu_cmd, bus.alu_start, bus.resp_valid, bus.resp_id,
                bus.resp_result, bus.resp_flags, bus.req0_ready, bus.req1_ready};
        tests_run++;
        if (outs !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
        end
        tests_run++;
        if ({bus1.alu_start, bus1.resp_valid, bus15.alu_start, bus15.resp_valid} !== 4'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_lat_builds: got %b expected 0000",
                     {bus1.alu_start, bus1.resp_valid, bus15.alu_start, bus15.resp_valid});
        end
        step();
        reset = 1'b0;
        bus.req0_valid = 1'b0;
    endtask

    task automatic test_single();
        step();
        bus.req1_valid = 1'b1; bus.req1_a = 32'h5; bus.req1_b = 32'h3; bus.req1_cmd = 3'd0;
        bus.req0_a = 32'h77; bus.req0_b = 32'h11;
        bus.resp_ready = 1'b1;
        #1;
        tests_run++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL single_ready: got %b expected 01", {bus.req0_ready, bus.req1_ready});
        end
        step();
        bus.req1_valid = 1'b0;
        tests_run++;
        if ({bus.alu_start, bus.alu_a, bus.alu_b, bus.alu_cmd, bus.req1_ready} !== {1'b1, 32'h5, 32'h3, 3'd0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL single_issue: got start=%b a=%h b=%h cmd=%0d rdy=%b expected 1/5/3/0/0",
                     bus.alu_start, bus.alu_a, bus.alu_b, bus.alu_cmd, bus.req1_ready);
        end
        step();
        tests_run++;
        if (bus.alu_start !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_start_pulse: got %b expected 0", bus.alu_start);
        end
        step();
        tests_run++;
        if (bus.resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_early_resp: got %b expected 0", bus.resp_valid);
        end
        step();
        tests_run++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_result} !== {1'b1, 1'b1, 32'h8}) begin
            tests_failed++;
            $display("[TB] FAIL single_resp: got v=%b id=%b r=%h expected 1/1/8",
                     bus.resp_valid, bus.resp_id, bus.resp_result);
        end
        step();
        tests_run++;
        if (bus.resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_resp_drop: got %b expected 0", bus.resp_valid);
        end
    endtask

    task automatic test_contention();
        logic [5:0]  ids;
        logic [31:0] results [6];
        int          n;
        logic        both_seen;
        n = 0;
        both_seen = 1'b0;
        ids = '0;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd10; bus.req0_b = 32'd1; bus.req0_cmd = 3'd1;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd5;  bus.req1_b = 32'd3; bus.req1_cmd = 3'd0;
        bus.resp_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && n < 6; cyc++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) both_seen = 1'b1;
            if (bus.resp_valid && bus.resp_ready) begin
                ids[n] = bus.resp_id;
                results[n] = bus.resp_result;
                n++;
                if (n == 6) begin
                    bus.req0_valid = 1'b0;
                    bus.req1_valid = 1'b0;
                end
            end
            step();
        end
        tests_run++;
        if (n != 6) begin
            tests_failed++;
            $display("[TB] FAIL contention_timeout: got %0d responses expected 6", n);
        end
        tests_run++;
        if (both_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL contention_both_ready: got %b expected 0", both_seen);
        end
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (ids[i] !== 1'(i % 2) || results[i] !== ((i % 2) ? 32'd8 : 32'd9)) begin
                tests_failed++;
                $display("[TB] FAIL contention_resp%0d: got id=%b r=%0d expected id=%0d r=%0d",
                         i, ids[i], results[i], i % 2, (i % 2) ? 8 : 9);
            end
        end
    endtask

    task automatic test_back_pressure();
        bus.req0_valid = 1'b1; bus.req0_a = 32'd7; bus.req0_b = 32'd2; bus.req0_cmd = 3'd2;
        bus.resp_ready = 1'b0;
        flags_drv = 4'b1010;
        #1;
        tests_run++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL bp_accept: got %b expected 10", {bus.req0_ready, bus.req1_ready});
        end
        step();
        bus.req0_valid = 1'b0;
        step();
        step();
        step();
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            tests_run++;
            if ({bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_flags, bus.req0_ready, bus.req1_ready}
                !== {1'b1, 1'b0, 32'h5, 4'b1010, 2'b00}) begin
                tests_failed++;
                $display("[TB] FAIL bp_hold%0d: got v=%b id=%b r=%h f=%b rdy=%b%b expected 1/0/5/1010/00",
                         i, bus.resp_valid, bus.resp_id, bus.resp_result, bus.resp_flags,
                         bus.req0_ready, bus.req1_ready);
            end
            if (i == 3) flags_drv = 4'b0000;
            step();
        end
        bus.resp_ready = 1'b1;
        bus.req1_valid = 1'b0;
        step();
        tests_run++;
        if ({bus.resp_valid, bus.alu_start} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL bp_release: got v=%b start=%b expected 00", bus.resp_valid, bus.alu_start);
        end
    endtask

    task automatic test_operand_capture();
        bus.req0_valid = 1'b1; bus.req0_a = 32'hDEAD_BEEF; bus.req0_b = 32'h1; bus.req0_cmd = 3'd0;
        bus.resp_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.req0_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL cap_accept: got %b expected 1", bus.req0_ready);
        end
        step();
        bus.req0_valid = 1'b0;
        bus.req0_a = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (bus.alu_a !== 32'hDEAD_BEEF) begin
                tests_failed++;
                $display("[TB] FAIL cap_hold%0d: got %h expected deadbeef", i, bus.alu_a);
            end
            step();
        end
        tests_run++;
        if ({bus.resp_valid, bus.resp_result} !== {1'b1, 32'hDEAD_BEF0}) begin
            tests_failed++;
            $display("[TB] FAIL cap_result: got v=%b r=%h expected 1/deadbef0", bus.resp_valid, bus.resp_result);
        end
        step();
    endtask

    task automatic test_reset_mid_wait();
        logic [107:0] outs;
        logic         resp_seen;
        logic         done;
        resp_seen = 1'b0;
        done = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd3; bus.req0_b = 32'd4; bus.req0_cmd = 3'd0;
        bus.resp_ready = 1'b1;
        step();
        bus.req0_valid = 1'b0;
        tests_run++;
        if (bus.alu_start !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rst_issue: got %b expected 1", bus.alu_start);
        end
        step();
        reset = 1'b1;
        #1;
        outs = {bus.alu_a, bus.alu_b, bus.alu_cmd, bus.alu_start, bus.resp_valid, bus.resp_id,
                bus.resp_result, bus.resp_flags, bus.req0_ready, bus.req1_ready};
        tests_run++;
        if (outs !== '0) begin
            tests_failed++;
            $display("[TB] FAIL rst_async_outputs: got %h expected 0", outs);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.resp_valid !== 1'b0) resp_seen = 1'b1;
            step();
        end
        tests_run++;
        if (resp_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_no_resp: got %b expected 0", resp_seen);
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        tests_run++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL rst_prio: got %b expected 10", {bus.req0_ready, bus.req1_ready});
        end
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.resp_valid) done = 1'b1;
            step();
        end
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rst_followup_timeout: got %b expected 1", done);
        end
    endtask

    task automatic test_latency();
        int          start1, resp1, start15, resp15;
        logic [31:0] res1, res15;
        logic [3:0]  fl1, fl15;
        start1 = -1; resp1 = -1; start15 = -1; resp15 = -1;
        res1 = '0; res15 = '0; fl1 = '0; fl15 = '0;
        flags_lat = 4'(1 << FLAG_ZERO);
        bus1.req0_valid = 1'b1;  bus1.req0_a = 32'd1;  bus1.req0_b = 32'd2;  bus1.req0_cmd = 3'd0;
        bus15.req0_valid = 1'b1; bus15.req0_a = 32'd1; bus15.req0_b = 32'd2; bus15.req0_cmd = 3'd0;
        bus1.resp_ready = 1'b1;
        bus15.resp_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (cyc == 1) begin
                bus1.req0_valid = 1'b0;
                bus15.req0_valid = 1'b0;
            end
            if (bus1.alu_start && start1 < 0) start1 = cyc;
            if (bus15.alu_start && start15 < 0) start15 = cyc;
            if (bus1.resp_valid && resp1 < 0) begin
                resp1 = cyc; res1 = bus1.resp_result; fl1 = bus1.resp_flags;
            end
            if (bus15.resp_valid && resp15 < 0) begin
                resp15 = cyc; res15 = bus15.resp_result; fl15 = bus15.resp_flags;
            end
            step();
        end
        tests_run++;
        if (start1 < 0 || resp1 - start1 != 2) begin
            tests_failed++;
            $display("[TB] FAIL lat1_cycles: got start=%0d resp=%0d expected distance 2", start1, resp1);
        end
        tests_run++;
        if (start15 < 0 || resp15 - start15 != 16) begin
            tests_failed++;
            $display("[TB] FAIL lat15_cycles: got start=%0d resp=%0d expected distance 16", start15, resp15);
        end
        tests_run++;
        if ({res1, fl1} !== {32'd3, 4'b0100}) begin
            tests_failed++;
            $display("[TB] FAIL lat1_resp: got r=%0d f=%b expected 3/0100", res1, fl1);
        end
        tests_run++;
        if ({res15, fl15} !== {32'd3, 4'b0100}) begin
            tests_failed++;
            $display("[TB] FAIL lat15_resp: got r=%0d f=%b expected 3/0100", res15, fl15);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        flags_drv = 4'b0000;
        flags_lat = 4'b0000;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cmd = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cmd = '0;
        bus.resp_ready = 1'b0;
        bus1.req0_valid = 1'b0; bus1.req0_a = '0; bus1.req0_b = '0; bus1.req0_cmd = '0;
        bus1.req1_valid = 1'b0; bus1.req1_a = '0; bus1.req1_b = '0; bus1.req1_cmd = '0;
        bus1.resp_ready = 1'b0;
        bus15.req0_valid = 1'b0; bus15.req0_a = '0; bus15.req0_b = '0; bus15.req0_cmd = '0;
        bus15.req1_valid = 1'b0; bus15.req1_a = '0; bus15.req1_b = '0; bus15.req1_cmd = '0;
        bus15.resp_ready = 1'b0;

        test_reset();
        test_single();
        test_contention();
        test_back_pressure();
        test_operand_capture();
        test_reset_mid_wait();
        test_latency();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU between two requesters (for example, a fetch/branch unit and an execute unit) using round-robin arbitration.
- Operand selection goes through two instances of the team's 32-bit 2:1 mux block, mux32layers2by1. Its select is driven by the grant, and ctl=1 selects requester 1.
- The block captures the selected operands, sequences a fixed-latency ALU operation and returns the result to the granted requester with a valid/ready handshake.

Parameters:
- WIDTH, 32, operand and result width. Must be 32 to match mux32layers2by1.
- ALU_LAT, 2, cycles from alu_start to a valid alu_result. Legal range 1..15.
- CMDW, 3, ALU command width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  32  requester 0 operands.
- req0_cmd  in  3  requester 0 ALU command.
- req1_valid, req1_ready, req1_a, req1_b, req1_cmd  same as above, for requester 1.
- alu_a, alu_b  out  32  registered operands to the ALU.
- alu_cmd  out  3  registered command to the ALU.
- alu_start  out  1  one-cycle start pulse.
- alu_result  in  32  ALU result.
- alu_flags  in  4  ALU flags {carryout, zero, overflow, negative}.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  1  requester that owns the response.
- resp_result  out  32  captured result.
- resp_flags  out  4  captured flags.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, prio = 0.
  - All outputs are 0: alu_a, alu_b, alu_cmd, alu_start, resp_*, req*_ready, counter.
  - Reset asserted mid-operation aborts the operation. No response is ever produced for it, and the requester must re-request.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant rule: gnt = req0_valid & ~req1_valid ? 0 : ~req0_valid & req1_valid ? 1 : prio.
  - If any valid: drive mux ctl = gnt and assert reqN_ready (N = gnt) combinationally for this one cycle.
  - On that edge: register the mux outputs into alu_a/alu_b, the selected cmd into alu_cmd and gnt into owner; set prio = ~gnt; go to ISSUE.
  - If no valid: stay in IDLE; req*_ready = 0.
- ISSUE: alu_start = 1 for exactly one cycle; load counter = ALU_LAT-1; go to WAIT.
- WAIT:
  - alu_a, alu_b and alu_cmd are held stable.
  - Counter decrements each cycle.
  - When counter == 0, on that edge capture alu_result and alu_flags into resp_result/resp_flags, set resp_id = owner, set resp_valid = 1, and go to RESP.
  - With ALU_LAT=1 this leaves exactly one WAIT cycle.
- RESP:
  - resp_valid stays high and resp_* stay stable until resp_valid & resp_ready.
  - On that edge: resp_valid = 0; go to IDLE.
  - No new grant is given in RESP (single outstanding operation).
- Latency: acceptance to resp_valid = ALU_LAT+2 cycles. Peak throughput is one operation per ALU_LAT+3 cycles with resp_ready tied high.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1. A lone requester is granted every slot.
- Simultaneous events: req*_valid changing during ISSUE/WAIT/RESP is ignored. Operands are sampled only on the IDLE acceptance edge, so a requester may drop valid and change data after its ready.
- req*_ready is never asserted for both requesters in the same cycle. It is never asserted outside IDLE.
- Arithmetic: the block performs none. Values are 32-bit pass-through, and the counter is 4 bits.

Decomposition:
- Shared package/include file: state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3) and the flag bit positions (carryout=3, zero=2, overflow=1, negative=0).
- Sub-modules: two mux32layers2by1 instances (A and B operand paths). A one-bit mux2by1 handles each command bit.
- A separate sub-module rr_pick2 (two-request round-robin grant logic from prio) is natural.

Test Plan:
- Reset mid-WAIT: reset asserted 1 cycle after alu_start -> all outputs 0 immediately (asynchronously); no resp_valid afterwards; next grant goes to requester 0.
- Single requester: req1 a=0x0000_0005, b=0x0000_0003, cmd=0, with the ALU model returning 8 after ALU_LAT=2 -> req1_ready for 1 cycle; alu_ctl=1; alu_a=5, alu_b=3; alu_start 1 cycle later; resp_valid 4 cycles after acceptance with resp_id=1 and resp_result=8.
- Contention: both valid continuously for 6 operations with resp_ready=1 -> resp_id sequence 0,1,0,1,0,1 and no cycle with both readies high.
- Back-pressure: resp_ready held 0 for 10 cycles in RESP -> resp_result/resp_flags/resp_id stable; no req*_ready; operation completes on the first resp_ready=1.
- Operand capture: req0 changes a from 0xDEAD_BEEF to 0 the cycle after acceptance -> alu_a stays 0xDEAD_BEEF through WAIT.
- ALU_LAT=1 and ALU_LAT=15 builds: alu_start-to-resp_valid of 2 and 16 cycles respectively; flags value 4'b0100 propagated to resp_flags.
